// File: rtl/hilo_muldiv_ctrl_if.sv
// Execute-stage request bus and HI/LO write port of the multiply/divide sequencer.
// The master is the pipeline side; the slave is hilo_muldiv_ctrl.
interface hilo_muldiv_ctrl_if;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_ready;
  logic        mf_req;
  logic        stall;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;
  logic        hi_we;
  logic        lo_we;
  logic        done;

  modport master (
    output op_valid, op_code, op_a, op_b, mf_req,
    input  op_ready, stall, hi_wdata, lo_wdata, hi_we, lo_we, done
  );

  modport slave (
    input  op_valid, op_code, op_a, op_b, mf_req,
    output op_ready, stall, hi_wdata, lo_wdata, hi_we, lo_we, done
  );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer and sole writer of the HI/LO pair.
// Sign-magnitude datapath: one bit per cycle, sign fix folded into the write-back registers.
module hilo_muldiv_ctrl (
  input  logic                clk,
  input  logic                reset,
  hilo_muldiv_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_WB} state_t;

  state_t      state_q, state_d;
  logic [63:0] acc_q, acc_d;      // MUL: {partial hi, multiplier}; DIV: {remainder, dividend/quotient}
  logic [31:0] opnd_q, opnd_d;    // multiplicand or divisor magnitude
  logic [4:0]  count_q, count_d;
  logic        neg_q, neg_d;
  logic        rneg_q, rneg_d;
  logic [31:0] hi_wdata_q, hi_wdata_d;
  logic [31:0] lo_wdata_q, lo_wdata_d;
  logic        hi_we_q, hi_we_d;
  logic        lo_we_q, lo_we_d;
  logic        done_q, done_d;
  logic        op_ready_q, op_ready_d;

  logic        accept;
  logic        is_signed;
  logic        sign_a, sign_b;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [63:0] mul_step;
  logic [32:0] div_shift;
  logic [33:0] div_trial;
  logic [63:0] div_step;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  assign accept    = bus.op_valid && op_ready_q;
  assign is_signed = ~bus.op_code[0];
  assign sign_a    = is_signed & bus.op_a[31];
  assign sign_b    = is_signed & bus.op_b[31];
  assign mag_a     = sign_a ? (~bus.op_a + 32'd1) : bus.op_a;
  assign mag_b     = sign_b ? (~bus.op_b + 32'd1) : bus.op_b;

  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    mul_step  = {mul_sum, acc_q[31:1]};
    div_shift = {acc_q[63:32], acc_q[31]};
    div_trial = {1'b0, div_shift} - {2'b00, opnd_q};
    // A partial remainder that is kept is always below the divisor, so bit 32 is zero.
    div_step  = div_trial[33] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                              : {div_trial[31:0], acc_q[30:0], 1'b1};
    prod_fix  = neg_q  ? (~mul_step + 64'd1)        : mul_step;
    quo_fix   = neg_q  ? (~div_step[31:0] + 32'd1)  : div_step[31:0];
    rem_fix   = rneg_q ? (~div_step[63:32] + 32'd1) : div_step[63:32];
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    count_d    = count_q;
    neg_d      = neg_q;
    rneg_d     = rneg_q;
    hi_wdata_d = hi_wdata_q;
    lo_wdata_d = lo_wdata_q;
    hi_we_d    = 1'b0;
    lo_we_d    = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (bus.op_code)
            3'b000, 3'b001: begin
              acc_d   = {32'd0, mag_b};
              opnd_d  = mag_a;
              neg_d   = sign_a ^ sign_b;
              count_d = 5'd0;
              state_d = S_MUL;
            end
            3'b010, 3'b011: begin
              if (bus.op_b == 32'd0) begin
                hi_wdata_d = bus.op_a;
                lo_wdata_d = 32'hFFFF_FFFF;
                hi_we_d    = 1'b1;
                lo_we_d    = 1'b1;
                done_d     = 1'b1;
                state_d    = S_WB;
              end else begin
                acc_d   = {32'd0, mag_a};
                opnd_d  = mag_b;
                neg_d   = sign_a ^ sign_b;
                rneg_d  = sign_a;
                count_d = 5'd0;
                state_d = S_DIV;
              end
            end
            3'b100: begin
              hi_wdata_d = bus.op_a;
              hi_we_d    = 1'b1;
            end
            3'b101: begin
              lo_wdata_d = bus.op_a;
              lo_we_d    = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        acc_d   = mul_step;
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) begin
          hi_wdata_d = prod_fix[63:32];
          lo_wdata_d = prod_fix[31:0];
          hi_we_d    = 1'b1;
          lo_we_d    = 1'b1;
          done_d     = 1'b1;
          state_d    = S_WB;
        end
      end
      S_DIV: begin
        acc_d   = div_step;
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) begin
          hi_wdata_d = rem_fix;
          lo_wdata_d = quo_fix;
          hi_we_d    = 1'b1;
          lo_we_d    = 1'b1;
          done_d     = 1'b1;
          state_d    = S_WB;
        end
      end
      S_WB: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    op_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      acc_q      <= 64'd0;
      opnd_q     <= 32'd0;
      count_q    <= 5'd0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      hi_wdata_q <= 32'd0;
      lo_wdata_q <= 32'd0;
      hi_we_q    <= 1'b0;
      lo_we_q    <= 1'b0;
      done_q     <= 1'b0;
      op_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      count_q    <= count_d;
      neg_q      <= neg_d;
      rneg_q     <= rneg_d;
      hi_wdata_q <= hi_wdata_d;
      lo_wdata_q <= lo_wdata_d;
      hi_we_q    <= hi_we_d;
      lo_we_q    <= lo_we_d;
      done_q     <= done_d;
      op_ready_q <= op_ready_d;
    end
  end

  assign bus.op_ready = op_ready_q;
  assign bus.stall    = (bus.op_valid || bus.mf_req) && (state_q != S_IDLE);
  assign bus.hi_wdata = hi_wdata_q;
  assign bus.lo_wdata = lo_wdata_q;
  assign bus.hi_we    = hi_we_q;
  assign bus.lo_we    = lo_we_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl: exact-cycle checks of results, handshake, stall and reset abort.
module tb_hilo_muldiv_ctrl;
  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_RSVD  = 3'b110;

  logic clk;
  logic reset;
  int   tests;
  int   failed;
  int   done_cnt;
  int   we_cnt;

  hilo_muldiv_ctrl_if bus ();

  hilo_muldiv_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    done_cnt = 0;
    we_cnt   = 0;
  end

  always @(negedge clk) begin
    if (bus.done) done_cnt = done_cnt + 1;
    if (bus.hi_we || bus.lo_we) we_cnt = we_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests = tests + 1;
    assert (obs === exp) else begin
      failed = failed + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one MULT/DIV class op and checks the 32-cycle iteration and the write-back cycle.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int d0;
    d0 = done_cnt;
    bus.op_valid = 1'b1;
    bus.op_code  = op;
    bus.op_a     = a;
    bus.op_b     = b;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    chk({tag, "_busy_ready"}, {31'd0, bus.op_ready}, 32'd0);
    repeat (32) @(posedge clk);
    #1;
    chk({tag, "_we"}, {30'd0, bus.hi_we, bus.lo_we}, 32'd3);
    chk({tag, "_hi"}, bus.hi_wdata, exp_hi);
    chk({tag, "_lo"}, bus.lo_wdata, exp_lo);
    @(posedge clk); #1;
    chk({tag, "_ready_after"}, {31'd0, bus.op_ready}, 32'd1);
    chk({tag, "_done_once"}, done_cnt - d0, 32'd1);
    $display("[TB] %s a=%h b=%h -> hi=%h lo=%h", tag, a, b, exp_hi, exp_lo);
  endtask

  initial begin
    int d0;
    int w0;
    tests        = 0;
    failed       = 0;
    reset        = 1'b1;
    bus.op_valid = 1'b0;
    bus.op_code  = 3'b000;
    bus.op_a     = 32'd0;
    bus.op_b     = 32'd0;
    bus.mf_req   = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, bus.op_ready}, 32'd1);
    chk("rst_we", {30'd0, bus.hi_we, bus.lo_we}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_hi", bus.hi_wdata, 32'd0);
    chk("rst_lo", bus.lo_wdata, 32'd0);
    chk("rst_stall", {31'd0, bus.stall}, 32'd0);
    $display("[TB] reset state checked");
    reset = 1'b0;
    @(posedge clk); #1;

    // MULT -2*3 with mf_req, MULTU held on the bus while busy
    d0 = done_cnt;
    bus.op_valid = 1'b1;
    bus.op_code  = OP_MULT;
    bus.op_a     = 32'hFFFF_FFFE;
    bus.op_b     = 32'd3;
    @(posedge clk); #1;
    bus.op_code = OP_MULTU;
    bus.mf_req  = 1'b1;
    chk("mult_busy_ready", {31'd0, bus.op_ready}, 32'd0);
    chk("mult_busy_stall", {31'd0, bus.stall}, 32'd1);
    repeat (32) @(posedge clk);
    #1;
    chk("mult_we", {29'd0, bus.hi_we, bus.lo_we, bus.done}, 32'd7);
    chk("mult_hi", bus.hi_wdata, 32'hFFFF_FFFF);
    chk("mult_lo", bus.lo_wdata, 32'hFFFF_FFFA);
    chk("mult_wb_stall", {31'd0, bus.stall}, 32'd1);
    chk("mult_wb_ready", {31'd0, bus.op_ready}, 32'd0);
    $display("[TB] MULT fffffffe*3 -> hi=ffffffff lo=fffffffa");
    @(posedge clk); #1;
    chk("mult_idle_ready", {31'd0, bus.op_ready}, 32'd1);
    chk("mult_idle_stall", {31'd0, bus.stall}, 32'd0);
    chk("mult_idle_we", {29'd0, bus.hi_we, bus.lo_we, bus.done}, 32'd0);
    bus.mf_req = 1'b0;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    chk("multu_accepted", {31'd0, bus.op_ready}, 32'd0);
    repeat (32) @(posedge clk);
    #1;
    chk("multu_we", {29'd0, bus.hi_we, bus.lo_we, bus.done}, 32'd7);
    chk("multu_hi", bus.hi_wdata, 32'h0000_0002);
    chk("multu_lo", bus.lo_wdata, 32'hFFFF_FFFA);
    $display("[TB] MULTU fffffffe*3 -> hi=00000002 lo=fffffffa");
    @(posedge clk); #1;
    chk("mul_pair_done", done_cnt - d0, 32'd2);

    // Further arithmetic vectors
    run_op("mult_negneg", OP_MULT, 32'hFFFF_FFFB, 32'hFFFF_FFF9, 32'h0000_0000, 32'h0000_0023);
    run_op("mult_minmin", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div_neg7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

    // DIVU 5/0 writes back immediately
    d0 = done_cnt;
    bus.op_valid = 1'b1;
    bus.op_code  = OP_DIVU;
    bus.op_a     = 32'd5;
    bus.op_b     = 32'd0;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    chk("div0_we", {29'd0, bus.hi_we, bus.lo_we, bus.done}, 32'd7);
    chk("div0_hi", bus.hi_wdata, 32'd5);
    chk("div0_lo", bus.lo_wdata, 32'hFFFF_FFFF);
    chk("div0_wb_ready", {31'd0, bus.op_ready}, 32'd0);
    @(posedge clk); #1;
    chk("div0_ready", {31'd0, bus.op_ready}, 32'd1);
    chk("div0_done_once", done_cnt - d0, 32'd1);
    $display("[TB] DIVU 5/0 -> hi=00000005 lo=ffffffff");

    // MTHI then MTLO on consecutive cycles
    bus.op_valid = 1'b1;
    bus.op_code  = OP_MTHI;
    bus.op_a     = 32'h1234_5678;
    @(posedge clk); #1;
    bus.op_code = OP_MTLO;
    bus.op_a    = 32'h9ABC_DEF0;
    chk("mthi_we", {29'd0, bus.hi_we, bus.lo_we, bus.done}, 32'd4);
    chk("mthi_data", bus.hi_wdata, 32'h1234_5678);
    chk("mthi_ready", {31'd0, bus.op_ready}, 32'd1);
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    chk("mtlo_we", {29'd0, bus.hi_we, bus.lo_we, bus.done}, 32'd2);
    chk("mtlo_data", bus.lo_wdata, 32'h9ABC_DEF0);
    chk("mtlo_ready", {31'd0, bus.op_ready}, 32'd1);
    @(posedge clk); #1;
    chk("mtxx_end_we", {29'd0, bus.hi_we, bus.lo_we, bus.done}, 32'd0);
    $display("[TB] MTHI 12345678 then MTLO 9abcdef0");

    // Reserved op code is a no-op
    bus.op_valid = 1'b1;
    bus.op_code  = OP_RSVD;
    bus.op_a     = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    chk("rsvd_we", {29'd0, bus.hi_we, bus.lo_we, bus.done}, 32'd0);
    chk("rsvd_ready", {31'd0, bus.op_ready}, 32'd1);
    $display("[TB] reserved op ignored");

    // Reset at cycle 10 of a DIV
    d0 = done_cnt;
    w0 = we_cnt;
    bus.op_valid = 1'b1;
    bus.op_code  = OP_DIV;
    bus.op_a     = 32'd1000;
    bus.op_b     = 32'd3;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_ready", {31'd0, bus.op_ready}, 32'd1);
    chk("abort_we", {29'd0, bus.hi_we, bus.lo_we, bus.done}, 32'd0);
    chk("abort_hi", bus.hi_wdata, 32'd0);
    chk("abort_lo", bus.lo_wdata, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt - d0, 32'd0);
    chk("abort_no_write", we_cnt - w0, 32'd0);
    bus.op_valid = 1'b1;
    bus.op_code  = OP_MTLO;
    bus.op_a     = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    chk("post_rst_we", {29'd0, bus.hi_we, bus.lo_we, bus.done}, 32'd2);
    chk("post_rst_lo", bus.lo_wdata, 32'hA5A5_A5A5);
    $display("[TB] reset abort during DIV, then MTLO a5a5a5a5");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_ctrl.md
# hilo_muldiv_ctrl

Iterative multiply/divide sequencer for the CPU's HI/LO register pair. It accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO from the execute stage and runs the multi-cycle arithmetic. It then drives the HI/LO write port and stalls the pipeline while a result is pending. It sits between the ALU-stage control and the HI/LO registers; the registers keep the architectural values, and this block is their only writer.

## Interface
- Parameters: none; datapath is fixed at 32 bits.
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- op_valid  in  1  operation request, sampled on rising clk
- op_code  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved (ignored, no effect)
- op_a  in  32  rs operand (multiplicand / dividend / MTxx data)
- op_b  in  32  rt operand (multiplier / divisor)
- op_ready  out  1  high in IDLE; a request is accepted only when op_valid && op_ready
- mf_req  in  1  MFHI/MFLO present in decode
- stall  out  1  combinational: (op_valid || mf_req) && busy
- hi_wdata  out  32  registered HI write data
- lo_wdata  out  32  registered LO write data
- hi_we  out  1  registered HI write enable, one-cycle pulse
- lo_we  out  1  registered LO write enable, one-cycle pulse
- done  out  1  one-cycle pulse with the result write of MULT/MULTU/DIV/DIVU

## Operation
- States: IDLE, MUL, DIV, WB. busy = (state != IDLE).
- IDLE, accept MULT/MULTU: latch |op_a|, |op_b| for signed ops (raw values for unsigned), latch the negate flag (sign_a ^ sign_b, signed only), count=0, go to MUL.
- MUL: radix-2 shift-add, one multiplier bit per cycle, 64-bit accumulator. After count==31 go to WB.
- IDLE, accept DIV/DIVU with op_b != 0: latch magnitudes, quotient sign (sign_a ^ sign_b) and remainder sign (sign_a), go to DIV.
- DIV: restoring division, one quotient bit per cycle. After count==31 go to WB.
- DIV/DIVU with op_b == 0: no iteration; go straight to WB with quotient 0xFFFFFFFF and remainder op_a (raw).
- WB: apply sign fixes (two's-complement negate, result taken mod 2^32 / 2^64). Drive HI=product[63:32] or remainder, LO=product[31:0] or quotient. Pulse hi_we, lo_we and done. Return to IDLE.
- MTHI/MTLO: accepted in IDLE. The next cycle has hi_we (or lo_we)=1 and the matching wdata=op_a, the other enable 0. State stays IDLE, so back-to-back MTxx are allowed every cycle.
- Reserved op_code: accepted as a no-op; no write occurs.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wraps; no trap).
- Signed MULT uses sign-magnitude with a final 64-bit negate; MULTU never negates.

## Timing
- Reset values: state IDLE, op_ready=1, hi_we=lo_we=done=0, hi_wdata=lo_wdata=0, stall=0.
- MULT/DIV accepted at edge E0: MUL/DIV occupies cycles E0+1..E0+32, WB is cycle E0+33 (enables high), op_ready is high from E0+34.
- Divide-by-zero: WB is cycle E0+1 and op_ready returns at E0+2.
- MTxx: write enable is high in cycle E0+1.
- Enables and wdata change only on clock edges; the enables are high for exactly one cycle.
- An MFHI/MFLO arriving the cycle after WB sees the new value. The HI/LO registers capture on the same edge that ends WB.
- Reset asserted mid-operation: aborts immediately, no write occurs, and any in-flight done/enable is cleared.
- op_valid while busy is ignored (not queued); stall keeps the pipeline holding it.

## Test plan
- MULT 0xFFFFFFFE (−2) × 3 -> after 34 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV 0xFFFFFFF9 (−7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/7 -> LO=14, HI=2; done high exactly once each.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0; DIVU 5/0 -> LO=0xFFFFFFFF, HI=5 at E0+1.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles -> hi_we then lo_we pulses with those data; op_ready never drops.
- mf_req asserted during a MULT -> stall=1 through WB and 0 the cycle after; a second MULT presented while busy is not accepted until op_ready.
- Reset pulsed at cycle 10 of a DIV -> no hi_we/lo_we/done; all outputs zero; a new op is accepted right after reset deasserts.
